// File: rtl/scene_loader_if.sv
// Byte-stream handshake between the host link and the scene loader.
// A byte moves on any rising edge where byte_valid and byte_ready are both high.
interface scene_loader_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;

  modport master (output byte_in, output byte_valid, input byte_ready);
  modport slave  (input byte_in, input byte_valid, output byte_ready);
endinterface

// File: rtl/scene_loader.sv
// Assembles a sync/payload/checksum scene packet into shadow registers and
// publishes it to the physics engine only after the checksum verifies.
module scene_loader #(
  parameter int SPRITES    = 9,
  parameter int WIDTH      = 32,
  parameter int DIMENSIONS = 2,
  parameter int TIMEOUT    = 65535
) (
  input  logic                                          clk_162,
  input  logic                                          rst_l,
  scene_loader_if.slave                                 bus,
  output logic [SPRITES-1:0][DIMENSIONS-1:0][WIDTH-1:0] init_locations,
  output logic [SPRITES-1:0][DIMENSIONS-1:0][WIDTH-1:0] init_velos,
  output logic [SPRITES-1:0][WIDTH/2-1:0]               masses,
  output logic [SPRITES-1:0][6:0]                       radii,
  output logic                                          data_ready,
  output logic                                          load_error
);

  localparam int LOC_B    = WIDTH / 8;
  localparam int MASS_B   = WIDTH / 16;
  localparam int VEL_OFS  = DIMENSIONS * LOC_B;
  localparam int MASS_OFS = 2 * DIMENSIONS * LOC_B;
  localparam int REC      = MASS_OFS + MASS_B + 1;
  localparam int SW       = $clog2(SPRITES + 1);
  localparam int BW       = $clog2(REC + 1);
  localparam int IW       = $clog2(TIMEOUT + 1);

  localparam logic [SW-1:0] SPR_LAST  = SW'(SPRITES - 1);
  localparam logic [BW-1:0] BYTE_LAST = BW'(REC - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);
  localparam logic [7:0]    SYNC      = 8'hA5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2,
    COMMIT  = 2'd3
  } state_t;

  state_t        state_r;
  logic [SW-1:0] spr_cnt_r;
  logic [BW-1:0] byte_cnt_r;
  logic [7:0]    xor_r;
  logic [IW-1:0] idle_cnt_r;
  logic          byte_ready_r;
  logic [7:0]    shadow_r [SPRITES][REC];

  logic          accept_s;
  logic          timeout_s;
  logic [SPRITES-1:0][DIMENSIONS-1:0][WIDTH-1:0] scene_loc_s;
  logic [SPRITES-1:0][DIMENSIONS-1:0][WIDTH-1:0] scene_velo_s;
  logic [SPRITES-1:0][WIDTH/2-1:0]               scene_mass_s;
  logic [SPRITES-1:0][6:0]                       scene_rad_s;

  assign bus.byte_ready = byte_ready_r;
  assign accept_s       = bus.byte_valid & byte_ready_r;
  assign timeout_s      = (idle_cnt_r == IDLE_LAST);

  // Shadow store: one byte slot per (sprite, byte-in-record), overwritten in place.
  always_ff @(posedge clk_162 or negedge rst_l) begin
    if (!rst_l) begin
      for (int s = 0; s < SPRITES; s++) begin
        for (int j = 0; j < REC; j++) begin
          shadow_r[s][j] <= 8'h00;
        end
      end
    end else if ((state_r == PAYLOAD) && accept_s) begin
      shadow_r[spr_cnt_r][byte_cnt_r] <= bus.byte_in;
    end
  end

  // Record layout decode: byte slots to fields, multi-byte fields LSB first.
  always_comb begin
    scene_loc_s  = '0;
    scene_velo_s = '0;
    scene_mass_s = '0;
    scene_rad_s  = '0;
    for (int s = 0; s < SPRITES; s++) begin
      for (int d = 0; d < DIMENSIONS; d++) begin
        for (int k = 0; k < LOC_B; k++) begin
          scene_loc_s[s][d][8*k +: 8]  = shadow_r[s][d*LOC_B + k];
          scene_velo_s[s][d][8*k +: 8] = shadow_r[s][VEL_OFS + d*LOC_B + k];
        end
      end
      for (int k = 0; k < MASS_B; k++) begin
        scene_mass_s[s][8*k +: 8] = shadow_r[s][MASS_OFS + k];
      end
      scene_rad_s[s] = shadow_r[s][REC-1][6:0];
    end
  end

  // Packet FSM with checksum, idle timer and the committed engine-facing outputs.
  always_ff @(posedge clk_162 or negedge rst_l) begin
    if (!rst_l) begin
      state_r        <= IDLE;
      spr_cnt_r      <= '0;
      byte_cnt_r     <= '0;
      xor_r          <= 8'h00;
      idle_cnt_r     <= '0;
      byte_ready_r   <= 1'b1;
      data_ready     <= 1'b0;
      load_error     <= 1'b0;
      init_locations <= '0;
      init_velos     <= '0;
      masses         <= '0;
      radii          <= '0;
    end else begin
      data_ready <= 1'b0;
      load_error <= 1'b0;
      case (state_r)
        IDLE: begin
          byte_ready_r <= 1'b1;
          if (accept_s && (bus.byte_in == SYNC)) begin
            spr_cnt_r  <= '0;
            byte_cnt_r <= '0;
            xor_r      <= 8'h00;
            idle_cnt_r <= '0;
            state_r    <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (accept_s) begin
            xor_r      <= xor_r ^ bus.byte_in;
            idle_cnt_r <= '0;
            if (byte_cnt_r == BYTE_LAST) begin
              byte_cnt_r <= '0;
              if (spr_cnt_r == SPR_LAST) begin
                state_r <= CHECK;
              end else begin
                spr_cnt_r <= spr_cnt_r + SW'(1);
              end
            end else begin
              byte_cnt_r <= byte_cnt_r + BW'(1);
            end
          end else if (timeout_s) begin
            load_error <= 1'b1;
            state_r    <= IDLE;
          end else begin
            idle_cnt_r <= idle_cnt_r + IW'(1);
          end
        end
        CHECK: begin
          if (accept_s) begin
            idle_cnt_r <= '0;
            if (bus.byte_in == xor_r) begin
              // Publish on the checksum edge so the scene and strobe appear together.
              init_locations <= scene_loc_s;
              init_velos     <= scene_velo_s;
              masses         <= scene_mass_s;
              radii          <= scene_rad_s;
              data_ready     <= 1'b1;
              byte_ready_r   <= 1'b0;
              state_r        <= COMMIT;
            end else begin
              load_error <= 1'b1;
              state_r    <= IDLE;
            end
          end else if (timeout_s) begin
            load_error <= 1'b1;
            state_r    <= IDLE;
          end else begin
            idle_cnt_r <= idle_cnt_r + IW'(1);
          end
        end
        COMMIT: begin
          byte_ready_r <= 1'b1;
          state_r      <= IDLE;
        end
        default: begin
          byte_ready_r <= 1'b1;
          state_r      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scene_loader.sv
// Directed bench for scene_loader: a default-timeout instance (a) and a
// TIMEOUT=100 instance (b) share the clock and a byte driver selected by sel.
module tb_scene_loader;
  localparam int SPR = 9;
  localparam int DIM = 2;
  localparam int W   = 32;
  localparam int REC = 19;
  localparam int PKT = 173;

  logic clk_162 = 1'b0;
  always #3 clk_162 = ~clk_162;

  logic       rst_a = 1'b1;
  logic       rst_b = 1'b1;
  logic       sel   = 1'b0;
  logic [7:0] vin   = 8'h00;
  logic       vval  = 1'b0;

  scene_loader_if bus_a ();
  scene_loader_if bus_b ();
  assign bus_a.byte_in    = vin;
  assign bus_a.byte_valid = vval & ~sel;
  assign bus_b.byte_in    = vin;
  assign bus_b.byte_valid = vval & sel;

  logic [SPR-1:0][DIM-1:0][W-1:0] loc_a, velo_a, loc_b, velo_b;
  logic [SPR-1:0][W/2-1:0]        mass_a, mass_b;
  logic [SPR-1:0][6:0]            rad_a, rad_b;
  logic                           dr_a, le_a, dr_b, le_b;

  scene_loader #(.TIMEOUT(65535)) dut_a (
    .clk_162(clk_162), .rst_l(rst_a), .bus(bus_a.slave),
    .init_locations(loc_a), .init_velos(velo_a), .masses(mass_a), .radii(rad_a),
    .data_ready(dr_a), .load_error(le_a)
  );

  scene_loader #(.TIMEOUT(100)) dut_b (
    .clk_162(clk_162), .rst_l(rst_b), .bus(bus_b.slave),
    .init_locations(loc_b), .init_velos(velo_b), .masses(mass_b), .radii(rad_b),
    .data_ready(dr_b), .load_error(le_b)
  );

  int checks = 0;
  int errors = 0;
  int n_dr_a = 0, n_le_a = 0, n_dr_b = 0, n_le_b = 0, n_both = 0;

  always @(posedge clk_162) begin
    if (dr_a) n_dr_a <= n_dr_a + 1;
    if (le_a) n_le_a <= n_le_a + 1;
    if (dr_b) n_dr_b <= n_dr_b + 1;
    if (le_b) n_le_b <= n_le_b + 1;
    if ((dr_a && le_a) || (dr_b && le_b)) n_both <= n_both + 1;
  end

  logic [31:0] e_loc  [SPR][DIM];
  logic [31:0] e_velo [SPR][DIM];
  logic [15:0] e_mass [SPR];
  logic [7:0]  e_rad  [SPR];
  logic [7:0]  pkt    [PKT];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic cur_dr();    return sel ? dr_b : dr_a; endfunction
  function automatic logic cur_le();    return sel ? le_b : le_a; endfunction
  function automatic logic cur_ready(); return sel ? bus_b.byte_ready : bus_a.byte_ready; endfunction

  task automatic build(input logic [7:0] seed);
    for (int s = 0; s < SPR; s++) begin
      for (int d = 0; d < DIM; d++) begin
        e_loc[s][d]  = {seed, 8'(s), 8'(d), 8'h3C};
        e_velo[s][d] = {8'(d), 8'h5A, 8'(s), seed};
      end
      e_mass[s] = {8'(s) + 8'h10, seed};
      e_rad[s]  = {seed[0], 7'(s * 9 + 1)};
    end
    if (seed == 8'd1) begin
      e_loc[0][0]  = 32'h0001_0000;
      e_loc[0][1]  = 32'hFFFF_0000;
      e_velo[0][0] = 32'h0000_0100;
      e_velo[0][1] = 32'h0000_0000;
      e_mass[0]    = 16'h0C00;
      e_rad[0]     = 8'h8A;
    end
  endtask

  function automatic logic [7:0] rec_byte(input int s, input int j);
    if (j < 8)       return e_loc[s][j/4][8*(j%4) +: 8];
    else if (j < 16) return e_velo[s][(j-8)/4][8*((j-8)%4) +: 8];
    else if (j < 18) return e_mass[s][8*(j-16) +: 8];
    else             return e_rad[s];
  endfunction

  task automatic make_pkt();
    logic [7:0] x;
    x      = 8'h00;
    pkt[0] = 8'hA5;
    for (int s = 0; s < SPR; s++) begin
      for (int j = 0; j < REC; j++) begin
        pkt[1 + s*REC + j] = rec_byte(s, j);
        x = x ^ rec_byte(s, j);
      end
    end
    pkt[PKT-1] = x;
  endtask

  // Entered and left at posedge+1; returns just after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int   tries;
    logic rdy;
    vval = 1'b0;
    if (gap > 0) begin
      repeat (gap) @(posedge clk_162);
      #1;
    end
    vin   = b;
    vval  = 1'b1;
    tries = 0;
    do begin
      rdy = cur_ready();
      @(posedge clk_162);
      #1;
      tries++;
    end while (!rdy && tries < 50);
    vval = 1'b0;
    chk("byte_accepted", 32'(rdy), 32'd1);
  endtask

  task automatic send_pkt(input int nbytes, input bit bad, input bit gaps);
    int         g;
    logic [7:0] b;
    for (int i = 0; i < nbytes; i++) begin
      g = 0;
      if (gaps) begin
        if (i == 100)       g = 1000;
        else if (i % 25 == 7) g = int'($urandom_range(1000, 200));
        else                g = int'($urandom_range(3, 0));
      end
      b = pkt[i];
      if (bad && (i == PKT-1)) b = b ^ 8'h01;
      send_byte(b, g);
    end
  endtask

  task automatic check_scene(input string tag);
    for (int s = 0; s < SPR; s++) begin
      for (int d = 0; d < DIM; d++) begin
        chk($sformatf("%s_loc%0d_%0d", tag, s, d), sel ? loc_b[s][d] : loc_a[s][d], e_loc[s][d]);
        chk($sformatf("%s_velo%0d_%0d", tag, s, d), sel ? velo_b[s][d] : velo_a[s][d], e_velo[s][d]);
      end
      chk($sformatf("%s_mass%0d", tag, s), 32'(sel ? mass_b[s] : mass_a[s]), 32'(e_mass[s]));
      chk($sformatf("%s_rad%0d", tag, s), 32'(sel ? rad_b[s] : rad_a[s]), 32'(e_rad[s][6:0]));
    end
  endtask

  // Called in the cycle after the checksum edge.
  task automatic expect_commit(input string tag);
    chk({tag, "_dr_n1"}, 32'(cur_dr()), 32'd1);
    chk({tag, "_le_n1"}, 32'(cur_le()), 32'd0);
    chk({tag, "_ready_n1"}, 32'(cur_ready()), 32'd0);
    check_scene(tag);
    @(posedge clk_162);
    #1;
    chk({tag, "_dr_n2"}, 32'(cur_dr()), 32'd0);
    chk({tag, "_ready_n2"}, 32'(cur_ready()), 32'd1);
  endtask

  initial begin
    #700000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sd, sl, n;
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (3) @(posedge clk_162);
    #1;
    chk("rst_loc", 32'(|loc_a), 32'd0);
    chk("rst_velo", 32'(|velo_a), 32'd0);
    chk("rst_mass", 32'(|mass_a), 32'd0);
    chk("rst_rad", 32'(|rad_a), 32'd0);
    chk("rst_dr", 32'(dr_a), 32'd0);
    chk("rst_le", 32'(le_a), 32'd0);
    chk("rst_ready", 32'(bus_a.byte_ready), 32'd1);
    rst_a = 1'b1;
    rst_b = 1'b1;
    @(posedge clk_162);
    #1;

    // Full packet with the hand-specified sprite 0.
    build(8'd1);
    make_pkt();
    sd = n_dr_a;
    send_pkt(PKT, 1'b0, 1'b0);
    chk("t1_loc0_1", loc_a[0][1], 32'hFFFF_0000);
    chk("t1_mass0", 32'(mass_a[0]), 32'h0000_0C00);
    chk("t1_rad0", 32'(rad_a[0]), 32'h0000_000A);
    expect_commit("t1");
    chk("t1_dr_pulses", 32'(n_dr_a - sd), 32'd1);

    // Same packet, corrupted checksum.
    sd = n_dr_a;
    sl = n_le_a;
    send_pkt(PKT, 1'b1, 1'b0);
    chk("t2_le_n1", 32'(le_a), 32'd1);
    chk("t2_dr_n1", 32'(dr_a), 32'd0);
    chk("t2_ready_n1", 32'(bus_a.byte_ready), 32'd1);
    @(posedge clk_162);
    #1;
    chk("t2_le_n2", 32'(le_a), 32'd0);
    chk("t2_le_pulses", 32'(n_le_a - sl), 32'd1);
    check_scene("t2a");
    // Different scene, corrupted checksum: outputs keep the seed-1 scene.
    build(8'd2);
    make_pkt();
    send_pkt(PKT, 1'b1, 1'b0);
    chk("t2b_le_n1", 32'(le_a), 32'd1);
    @(posedge clk_162);
    #1;
    build(8'd1);
    check_scene("t2b");
    chk("t2_dr_pulses", 32'(n_dr_a - sd), 32'd0);

    // Garbage before sync, 0xA5 inside the payload.
    build(8'd3);
    e_loc[3][0] = 32'hA512_A5A5;
    make_pkt();
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    send_byte(8'hFF, 0);
    send_pkt(PKT, 1'b0, 1'b0);
    expect_commit("t3");

    // Long valid gaps well inside the default timeout.
    build(8'd4);
    make_pkt();
    sl = n_le_a;
    send_pkt(PKT, 1'b0, 1'b1);
    expect_commit("t4");
    chk("t4_no_error", 32'(n_le_a - sl), 32'd0);

    // TIMEOUT=100 instance: stall after payload byte 50.
    sel = 1'b1;
    build(8'd5);
    make_pkt();
    sl = n_le_b;
    send_pkt(51, 1'b0, 1'b0);
    n = 0;
    while (!le_b && n < 400) begin
      @(posedge clk_162);
      #1;
      n++;
    end
    checks++;
    assert (n >= 99 && n <= 101) else begin
      errors++;
      $error("FAIL t5_timeout_cycles observed=%0d expected=100", n);
    end
    @(posedge clk_162);
    #1;
    chk("t5_le_pulses", 32'(n_le_b - sl), 32'd1);
    chk("t5_no_commit", 32'(n_dr_b), 32'd0);
    send_pkt(PKT, 1'b0, 1'b0);
    expect_commit("t5");

    // Reset mid-payload on instance a.
    sel = 1'b0;
    build(8'd6);
    make_pkt();
    send_pkt(31, 1'b0, 1'b0);
    sd = n_dr_a;
    sl = n_le_a;
    rst_a = 1'b0;
    #1;
    chk("t6_loc_zero", 32'(|loc_a), 32'd0);
    chk("t6_velo_zero", 32'(|velo_a), 32'd0);
    chk("t6_mass_zero", 32'(|mass_a), 32'd0);
    chk("t6_rad_zero", 32'(|rad_a), 32'd0);
    chk("t6_ready", 32'(bus_a.byte_ready), 32'd1);
    repeat (2) @(posedge clk_162);
    #1;
    rst_a = 1'b1;
    @(posedge clk_162);
    #1;
    chk("t6_no_dr", 32'(n_dr_a - sd), 32'd0);
    chk("t6_no_le", 32'(n_le_a - sl), 32'd0);
    send_pkt(PKT, 1'b0, 1'b0);
    expect_commit("t6");

    chk("strobe_overlap", 32'(n_both), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/scene_loader.md
# scene_loader

Byte-stream receiver that assembles a complete initial scene (per-sprite locations, velocities, masses, radii) and presents it to the physics engine's `init_*` inputs with a one-cycle `data_ready` strobe. It sits between the host link (UART/byte FIFO) and the physics engine. All fields are collected into shadow registers, the checksum is verified, and only then are the engine-facing outputs updated, so the engine never sees a partially loaded scene.

## Interface
- `SPRITES`, 9, number of sprites per scene
- `WIDTH`, 32, location/velocity field width in bits; must be a multiple of 16
- `DIMENSIONS`, 2, axes per sprite
- `TIMEOUT`, 65535, idle cycles allowed between accepted bytes mid-packet
- `clk_162`  in  1  system clock; all logic on rising edge
- `rst_l`  in  1  reset, asynchronous, active-low
- `byte_in`  in  8  stream data
- `byte_valid`  in  1  `byte_in` valid
- `byte_ready`  out  1  loader can accept; a transfer occurs when `byte_valid && byte_ready`
- `init_locations`  out  `[SPRITES-1:0][DIMENSIONS-1:0][WIDTH-1:0]`  committed locations
- `init_velos`  out  `[SPRITES-1:0][DIMENSIONS-1:0][WIDTH-1:0]`  committed velocities
- `masses`  out  `[SPRITES-1:0][WIDTH/2-1:0]`  committed masses
- `radii`  out  `[SPRITES-1:0][6:0]`  committed radii
- `data_ready`  out  1  one-cycle strobe: new scene is on the outputs
- `load_error`  out  1  one-cycle strobe: packet discarded (bad checksum or timeout)

## Operation
- Packet: sync byte 0xA5, then sprite 0..SPRITES-1 records, then one checksum byte.
- Sprite record, in order: loc[0], loc[1], ..., velo[0], velo[1], ... (each WIDTH/8 bytes, LSB first), mass (WIDTH/16 bytes, LSB first), radius (1 byte; bit 7 ignored). Record length is R = 2·DIMENSIONS·WIDTH/8 + WIDTH/16 + 1, which is 19 at the defaults. The payload is SPRITES·R bytes, 171 at the defaults.
- Checksum: the XOR of all payload bytes. The sync byte is excluded.
- States:
  - IDLE: `byte_ready`=1. An accepted 0xA5 clears the byte counter and running XOR and moves to PAYLOAD. Any other accepted byte is dropped silently.
  - PAYLOAD: `byte_ready`=1. Each accepted byte is written into its shadow-register slot, indexed by sprite counter and byte-in-record counter, and XORed into the running checksum. After the last payload byte, move to CHECK. A 0xA5 inside the payload is ordinary data.
  - CHECK: `byte_ready`=1. If the accepted byte equals the running XOR, move to COMMIT. Otherwise assert `load_error` and return to IDLE; the outputs are unchanged.
  - COMMIT: `byte_ready`=0. The shadow registers are copied to the outputs and `data_ready`=1. Next state is IDLE.
- Timeout: an idle counter runs in PAYLOAD and CHECK, clears on every accepted byte, and clears on entry to PAYLOAD. When it reaches TIMEOUT, `load_error` is asserted and the state returns to IDLE. The counter does not run in IDLE.
- Shadow registers are overwritten in place. A discarded packet leaves stale shadow contents, which is harmless because every byte is rewritten before the next commit.
- `data_ready` and `load_error` are never asserted in the same cycle.

## Timing
- Reset (async assert, sync release):
  - state = IDLE; counters, running XOR and shadow registers = 0
  - all `init_*`, `masses`, `radii` = 0
  - `data_ready` = 0, `load_error` = 0
  - `byte_ready` = 1 (decoded from IDLE)
- `byte_ready` is a registered-state decode only; it has no combinational path from `byte_valid`.
- Checksum byte accepted at edge N → outputs hold the new scene and `data_ready`=1 in cycle N+1 → `data_ready`=0 at N+2. The outputs are stable from N+1 until the next commit.
- Bad checksum accepted at edge N → `load_error`=1 in cycle N+1, state is IDLE, and `byte_ready`=1 in that same cycle.
- A back-to-back packet is possible. Minimum packet period = SPRITES·R + 3 cycles (sync + payload + checksum + COMMIT); 174 at the defaults.
- `byte_valid` low stalls the loader indefinitely in IDLE. In PAYLOAD and CHECK it stalls up to TIMEOUT cycles.
- `rst_l` asserted mid-packet aborts immediately to reset values with no strobe. The next packet must start with a new sync byte.

## Test plan
- Reset, then a full 173-byte packet at the defaults with sprite 0: loc = (0x00010000, 0xFFFF0000), velo = (0x00000100, 0), mass = 0x0C00, radius = 0x8A. The remaining sprites use index-derived values and the checksum is correct. Required: one `data_ready` pulse; `init_locations[0][1]` = 0xFFFF0000; `masses[0]` = 0x0C00; `radii[0]` = 0x0A; all other fields match.
- Same packet with the checksum byte XOR 0x01. Required: `load_error` pulse one cycle after the checksum byte; no `data_ready`; outputs still equal the previous scene.
- Bytes 0x00, 0x13, 0xFF before the sync, and 0xA5 embedded in sprite 3 loc[0]. Required: the garbage bytes are ignored, the embedded 0xA5 lands in the field, and the commit is correct.
- Random `byte_valid` gaps of up to 1000 cycles, with TIMEOUT=65535. Required: the commit is identical to the gap-free case.
- TIMEOUT=100, stop after payload byte 50 and hold `byte_valid` low. Required: `load_error` pulses about 100 cycles after the last accepted byte; a following full packet commits correctly.
- Assert `rst_l`=0 mid-payload for 2 cycles. Required: all outputs 0 immediately with no strobe; a full packet afterwards commits correctly.
